// File: rtl/sprite_line_eval.sv
// Per-scanline sprite evaluator: scans OAM once per line and copies the entries
// that cover line_y into the line sprite buffer, flagging overflow past MAX_PER_LINE.
module sprite_line_eval #(
  parameter int NUM_SPRITES  = 64,
  parameter int MAX_PER_LINE = 8,
  parameter int SPRITE_H     = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        line_start,
  input  logic [9:0]  line_y,
  output logic        oam_rd,
  output logic [7:0]  oam_raddr,
  input  logic [31:0] oam_rdata,
  output logic        slot_we,
  output logic [3:0]  slot_idx,
  output logic [31:0] slot_data,
  output logic [3:0]  slot_count,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [1:0]  dbg_state
);

  // OAM read protocol: oam_rd/oam_raddr issue a read in one cycle and
  // oam_rdata carries that entry in the following cycle; there is no stall.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] LAST_ADDR = 8'(NUM_SPRITES - 1);
  localparam logic [3:0] MAX_SLOTS = 4'(MAX_PER_LINE);

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [9:0]  y_q;
  logic        rd_valid_q;
  logic [3:0]  count_q;
  logic        ovf_q;

  logic [10:0] dy;
  logic        hit;
  logic        eval;
  logic        take;
  logic        ovf_hit;

  // Evaluation of the returned entry; a new line_start discards it.
  always_comb begin
    dy      = {1'b0, y_q} - {1'b0, oam_rdata[19:10]};
    hit     = oam_rdata[27] && (y_q >= oam_rdata[19:10]) && (dy < 11'(SPRITE_H));
    eval    = rd_valid_q && ((state_q == SCAN) || (state_q == DRAIN)) && !line_start;
    take    = eval && hit && (count_q < MAX_SLOTS);
    ovf_hit = eval && hit && (count_q >= MAX_SLOTS);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: ;
      SCAN: begin
        if (ovf_hit)                state_d = DONE;
        else if (addr_q == LAST_ADDR) state_d = DRAIN;
        else                        addr_d  = addr_q + 8'd1;
      end
      DRAIN: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (line_start) begin
      state_d = SCAN;
      addr_d  = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= 8'd0;
      y_q        <= 10'd0;
      rd_valid_q <= 1'b0;
      count_q    <= 4'd0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_valid_q <= oam_rd && !line_start && !ovf_hit;
      if (line_start) begin
        y_q     <= line_y;
        count_q <= 4'd0;
        ovf_q   <= 1'b0;
      end else begin
        if (take)    count_q <= count_q + 4'd1;
        if (ovf_hit) ovf_q   <= 1'b1;
      end
    end
  end

  always_comb begin
    oam_rd     = (state_q == SCAN);
    oam_raddr  = oam_rd ? addr_q : 8'd0;
    slot_we    = take;
    slot_idx   = take ? count_q : 4'd0;
    slot_data  = take ? oam_rdata : 32'd0;
    slot_count = count_q;
    busy       = (state_q == SCAN) || (state_q == DRAIN);
    done       = (state_q == DONE);
    overflow   = ovf_q || ovf_hit;
    dbg_state  = state_q;
  end

endmodule
